esc_tx_serializer: RTL and testbench

- Upstream feeder of the escape-mode line encoder on the Tx escape clock.
- Accepts an escape request plus mode (LPDT, ULPS or trigger) and LPDT payload bytes over a PPI-style valid/ready handshake.
- Produces the one-bit-per-cycle stream EscBit/DataValid/EscEncoderEn that the encoder turns into spaced-one-hot line states: 8-bit entry command MSB-first, then payload bytes LSB-first, then spaces while paused or held.

---
 rtl/esc_tx_serializer.sv | 174 +++++++++++++++++
 tb/tb_esc_tx_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_tx_serializer.sv
// Escape-mode Tx serializer: turns an escape request (LPDT/ULPS/trigger) plus payload
// bytes into the one-bit-per-cycle mark/space stream consumed by the line encoder.
module esc_tx_serializer #(
    parameter logic [7:0] CMD_LPDT  = 8'hE1,
    parameter logic [7:0] CMD_ULPS  = 8'h1E,
    parameter logic [7:0] CMD_TRIG0 = 8'h62,
    parameter logic [7:0] CMD_TRIG1 = 8'h5D,
    parameter logic [7:0] CMD_TRIG2 = 8'h21,
    parameter logic [7:0] CMD_TRIG3 = 8'hA0
) (
    input  logic       TxClkEsc,
    input  logic       Rst,
    input  logic       TxRequestEsc,
    input  logic       TxLpdtEsc,
    input  logic       TxUlpsEsc,
    input  logic [3:0] TxTriggerEsc,
    input  logic [7:0] TxDataEsc,
    input  logic       TxValidEsc,
    output logic       TxReadyEsc,
    output logic       EscBit,
    output logic       DataValid,
    output logic       EscEncoderEn,
    output logic       UlpsActiveNot,
    output logic       EscBusy
);

    typedef enum logic [2:0] {IDLE, CMD, DATA, PAUSE, ULPS, TRIG} state_t;
    typedef enum logic [1:0] {MODE_LPDT, MODE_ULPS, MODE_TRIG} mode_t;

    state_t     state, stateNxt;
    mode_t      mode, modeNxt;
    logic [7:0] shiftReg, shiftNxt;
    logic [2:0] bitCnt, cntNxt;
    logic       bitNxt, readyNxt;

    logic       reqHit;
    mode_t      reqMode;
    logic [7:0] reqCmd;

    // Mode priority: LPDT, then ULPS, then the lowest set trigger bit.
    always_comb begin
        reqHit  = 1'b1;
        reqMode = MODE_LPDT;
        reqCmd  = CMD_LPDT;
        if (TxLpdtEsc) begin
            reqMode = MODE_LPDT;
            reqCmd  = CMD_LPDT;
        end else if (TxUlpsEsc) begin
            reqMode = MODE_ULPS;
            reqCmd  = CMD_ULPS;
        end else if (TxTriggerEsc[0]) begin
            reqMode = MODE_TRIG;
            reqCmd  = CMD_TRIG0;
        end else if (TxTriggerEsc[1]) begin
            reqMode = MODE_TRIG;
            reqCmd  = CMD_TRIG1;
        end else if (TxTriggerEsc[2]) begin
            reqMode = MODE_TRIG;
            reqCmd  = CMD_TRIG2;
        end else if (TxTriggerEsc[3]) begin
            reqMode = MODE_TRIG;
            reqCmd  = CMD_TRIG3;
        end else begin
            reqHit  = 1'b0;
        end
    end

    // shiftReg holds the bits still to be sent; the bit on EscBit has already left it.
    always_comb begin
        stateNxt = state;
        modeNxt  = mode;
        shiftNxt = shiftReg;
        cntNxt   = bitCnt;
        bitNxt   = 1'b0;
        readyNxt = 1'b0;
        case (state)
            IDLE: begin
                if (TxRequestEsc && reqHit) begin
                    stateNxt = CMD;
                    modeNxt  = reqMode;
                    bitNxt   = reqCmd[7];
                    shiftNxt = {reqCmd[6:0], 1'b0};
                    cntNxt   = 3'd0;
                end
            end
            CMD: begin
                if (bitCnt == 3'd7) begin
                    cntNxt = 3'd0;
                    if (!TxRequestEsc) begin
                        stateNxt = IDLE;
                    end else if (mode == MODE_ULPS) begin
                        stateNxt = ULPS;
                    end else if (mode == MODE_TRIG) begin
                        stateNxt = TRIG;
                    end else if (TxValidEsc) begin
                        stateNxt = DATA;
                        bitNxt   = TxDataEsc[0];
                        shiftNxt = {1'b0, TxDataEsc[7:1]};
                        readyNxt = 1'b1;
                    end else begin
                        stateNxt = PAUSE;
                    end
                end else begin
                    bitNxt   = shiftReg[7];
                    shiftNxt = {shiftReg[6:0], 1'b0};
                    cntNxt   = bitCnt + 3'd1;
                end
            end
            DATA: begin
                if (bitCnt == 3'd7) begin
                    cntNxt = 3'd0;
                    if (!TxRequestEsc) begin
                        stateNxt = IDLE;
                    end else if (TxValidEsc) begin
                        bitNxt   = TxDataEsc[0];
                        shiftNxt = {1'b0, TxDataEsc[7:1]};
                        readyNxt = 1'b1;
                    end else begin
                        stateNxt = PAUSE;
                    end
                end else begin
                    bitNxt   = shiftReg[0];
                    shiftNxt = {1'b0, shiftReg[7:1]};
                    cntNxt   = bitCnt + 3'd1;
                end
            end
            PAUSE: begin
                if (!TxRequestEsc) begin
                    stateNxt = IDLE;
                end else if (TxValidEsc) begin
                    stateNxt = DATA;
                    bitNxt   = TxDataEsc[0];
                    shiftNxt = {1'b0, TxDataEsc[7:1]};
                    readyNxt = 1'b1;
                    cntNxt   = 3'd0;
                end
            end
            ULPS, TRIG: begin
                if (!TxRequestEsc) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the bit being presented.
    always_ff @(posedge TxClkEsc or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            mode          <= MODE_LPDT;
            shiftReg      <= 8'd0;
            bitCnt        <= 3'd0;
            TxReadyEsc    <= 1'b0;
            EscBit        <= 1'b0;
            DataValid     <= 1'b0;
            EscEncoderEn  <= 1'b0;
            UlpsActiveNot <= 1'b1;
            EscBusy       <= 1'b0;
        end else begin
            state         <= stateNxt;
            mode          <= modeNxt;
            shiftReg      <= shiftNxt;
            bitCnt        <= cntNxt;
            TxReadyEsc    <= readyNxt;
            EscBit        <= bitNxt;
            DataValid     <= (stateNxt == CMD) || (stateNxt == DATA);
            EscEncoderEn  <= (stateNxt != IDLE);
            UlpsActiveNot <= (stateNxt != ULPS);
            EscBusy       <= (stateNxt != IDLE);
        end
    end

endmodule

// File: tb/tb_esc_tx_serializer.sv
// Bench for esc_tx_serializer: each transaction is planned up front as an input timeline
// plus the expected per-cycle output trace, then replayed against the DUT.
module tb_esc_tx_serializer;

    localparam int MAXL = 200;
    // Output vector layout: {TxReadyEsc, EscBit, DataValid, EscEncoderEn, UlpsActiveNot, EscBusy}
    localparam logic [5:0] IDLE_V = 6'b000010;

    logic       TxClkEsc = 1'b0;
    logic       Rst;
    logic       TxRequestEsc;
    logic       TxLpdtEsc;
    logic       TxUlpsEsc;
    logic [3:0] TxTriggerEsc;
    logic [7:0] TxDataEsc;
    logic       TxValidEsc;
    logic       TxReadyEsc;
    logic       EscBit;
    logic       DataValid;
    logic       EscEncoderEn;
    logic       UlpsActiveNot;
    logic       EscBusy;
    logic [5:0] outs;

    esc_tx_serializer dut (
        .TxClkEsc      (TxClkEsc),
        .Rst           (Rst),
        .TxRequestEsc  (TxRequestEsc),
        .TxLpdtEsc     (TxLpdtEsc),
        .TxUlpsEsc     (TxUlpsEsc),
        .TxTriggerEsc  (TxTriggerEsc),
        .TxDataEsc     (TxDataEsc),
        .TxValidEsc    (TxValidEsc),
        .TxReadyEsc    (TxReadyEsc),
        .EscBit        (EscBit),
        .DataValid     (DataValid),
        .EscEncoderEn  (EscEncoderEn),
        .UlpsActiveNot (UlpsActiveNot),
        .EscBusy       (EscBusy)
    );

    always #5 TxClkEsc = ~TxClkEsc;

    assign outs = {TxReadyEsc, EscBit, DataValid, EscEncoderEn, UlpsActiveNot, EscBusy};

    int checks = 0;
    int errors = 0;

    // Plan: inputs sampled at edge k, expected outputs during cycle k (cycle 1 follows edge 0).
    logic       reqA [0:MAXL];
    logic       vldA [0:MAXL];
    logic [7:0] datA [0:MAXL];
    logic [5:0] expA [0:MAXL];
    int         L;
    logic       modeL, modeU;
    logic [3:0] modeT;
    logic [7:0] bytesQ [$];
    int         gapsQ  [$];

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outv(input logic rdy, input logic b, input logic dv,
                                        input logic en, input logic un, input logic busy);
        return {rdy, b, dv, en, un, busy};
    endfunction

    function automatic logic [7:0] trigCmd(input logic [3:0] t);
        if (t[0]) return 8'h62;
        if (t[1]) return 8'h5D;
        if (t[2]) return 8'h21;
        return 8'hA0;
    endfunction

    task automatic pushOut(input logic [5:0] v);
        L++;
        expA[L] = v;
    endtask

    task automatic clearPlan();
        L = 0;
        for (int k = 0; k <= MAXL; k++) begin
            reqA[k] = 1'b1;
            vldA[k] = 1'($urandom);
            datA[k] = 8'($urandom);
        end
    endtask

    task automatic pushCmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) pushOut(outv(1'b0, c[i], 1'b1, 1'b1, 1'b1, 1'b1));
    endtask

    // LPDT: command, then each byte after its gap of pause cycles, then tail pauses, then drop.
    task automatic planLpdt(input int tailPause, input int dropBack);
        int pos;
        int drop;
        logic [7:0] b;
        pushCmd(8'hE1);
        pos = L;
        for (int j = 0; j < bytesQ.size(); j++) begin
            b = bytesQ[j];
            for (int t = 0; t < gapsQ[j]; t++) begin
                vldA[pos] = 1'b0;
                pushOut(outv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
                pos = L;
            end
            vldA[pos] = 1'b1;
            datA[pos] = b;
            for (int i = 0; i < 8; i++) pushOut(outv(i == 0, b[i], 1'b1, 1'b1, 1'b1, 1'b1));
            pos = L;
        end
        for (int t = 0; t < tailPause; t++) begin
            vldA[pos] = 1'b0;
            pushOut(outv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
            pos = L;
        end
        drop = (tailPause > 0) ? pos : pos - dropBack;
        for (int k = drop; k <= pos; k++) reqA[k] = 1'b0;
        pushOut(IDLE_V);
    endtask

    // ULPS / trigger: command, hold for `hold` cycles, then request drops.
    task automatic planHold(input logic [7:0] c, input logic ulps, input int hold, input int dropBack);
        int pos;
        pushCmd(c);
        for (int t = 0; t < hold; t++) pushOut(outv(1'b0, 1'b0, 1'b0, 1'b1, !ulps, 1'b1));
        pos = L;
        reqA[pos] = 1'b0;
        if (hold == 0) begin
            for (int k = pos - dropBack; k <= pos; k++) reqA[k] = 1'b0;
        end
        pushOut(IDLE_V);
    endtask

    task automatic runPlan(input string name, input int upto);
        for (int k = 0; k < L && k < upto; k++) begin
            TxRequestEsc = reqA[k];
            TxValidEsc   = vldA[k];
            TxDataEsc    = datA[k];
            if (k == 0) begin
                TxLpdtEsc    = modeL;
                TxUlpsEsc    = modeU;
                TxTriggerEsc = modeT;
            end else begin
                TxLpdtEsc    = 1'($urandom);
                TxUlpsEsc    = 1'($urandom);
                TxTriggerEsc = 4'($urandom);
            end
            @(posedge TxClkEsc);
            @(negedge TxClkEsc);
            checkVal($sformatf("%s cyc%0d", name, k + 1), {2'b00, outs}, {2'b00, expA[k + 1]});
        end
    endtask

    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                TxRequestEsc = 1'b0;
                TxLpdtEsc    = 1'($urandom);
                TxUlpsEsc    = 1'($urandom);
                TxTriggerEsc = 4'($urandom);
            end else begin
                TxRequestEsc = 1'b1;
                TxLpdtEsc    = 1'b0;
                TxUlpsEsc    = 1'b0;
                TxTriggerEsc = 4'b0000;
            end
            TxValidEsc = 1'($urandom);
            TxDataEsc  = 8'($urandom);
            @(posedge TxClkEsc);
            @(negedge TxClkEsc);
            checkVal("idle", {2'b00, outs}, {2'b00, IDLE_V});
        end
    endtask

    initial begin
        Rst          = 1'b1;
        TxRequestEsc = 1'b0;
        TxLpdtEsc    = 1'b0;
        TxUlpsEsc    = 1'b0;
        TxTriggerEsc = 4'b0000;
        TxDataEsc    = 8'h00;
        TxValidEsc   = 1'b0;
        @(negedge TxClkEsc);
        @(negedge TxClkEsc);
        checkVal("reset", {2'b00, outs}, {2'b00, IDLE_V});
        Rst = 1'b0;
        idleGap(2);

        clearPlan(); modeL = 1'b1; modeU = 1'b0; modeT = 4'b0000;
        bytesQ = '{8'hA5}; gapsQ = '{0};
        planLpdt(0, 4);
        runPlan("lpdtA5", MAXL);
        idleGap(2);

        // Reset pulse while bit 3 of the byte is on the line.
        clearPlan();
        bytesQ = '{8'hA5}; gapsQ = '{0};
        planLpdt(0, 0);
        runPlan("rstmid", 12);
        Rst = 1'b1;
        #1;
        checkVal("rstmid async", {2'b00, outs}, {2'b00, IDLE_V});
        @(posedge TxClkEsc);
        @(negedge TxClkEsc);
        checkVal("rstmid held", {2'b00, outs}, {2'b00, IDLE_V});
        Rst = 1'b0;
        idleGap(1);
        clearPlan();
        bytesQ = '{8'h5A}; gapsQ = '{0};
        planLpdt(0, 0);
        runPlan("afterRst", MAXL);
        idleGap(2);

        clearPlan(); modeL = 1'b1; modeU = 1'b0; modeT = 4'b0000;
        bytesQ = '{8'h01, 8'h80}; gapsQ = '{0, 0};
        planLpdt(0, 0);
        runPlan("b2b", MAXL);
        idleGap(2);

        clearPlan();
        bytesQ = '{8'hC3}; gapsQ = '{5};
        planLpdt(1, 0);
        runPlan("pause5", MAXL);
        idleGap(2);

        clearPlan(); modeL = 1'b0; modeU = 1'b1; modeT = 4'b0000;
        planHold(8'h1E, 1'b1, 4, 0);
        runPlan("ulps", MAXL);
        idleGap(2);

        clearPlan(); modeL = 1'b0; modeU = 1'b0; modeT = 4'b0110;
        planHold(8'h5D, 1'b0, 3, 0);
        runPlan("trig0110", MAXL);
        idleGap(2);

        clearPlan(); modeL = 1'b1; modeU = 1'b1; modeT = 4'b1111;
        bytesQ = '{8'h3C}; gapsQ = '{1};
        planLpdt(0, 7);
        runPlan("lpdtPrio", MAXL);
        idleGap(2);

        for (int n = 0; n < 40; n++) begin
            int kind;
            int nb;
            clearPlan();
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                modeL = 1'b1; modeU = 1'($urandom); modeT = 4'($urandom);
                nb = $urandom_range(0, 3);
                bytesQ = {}; gapsQ = {};
                for (int j = 0; j < nb; j++) begin
                    bytesQ.push_back(8'($urandom));
                    gapsQ.push_back(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3));
                end
                planLpdt($urandom_range(0, 2), $urandom_range(0, 7));
                runPlan($sformatf("rnd%0d lpdt", n), MAXL);
            end else if (kind == 1) begin
                modeL = 1'b0; modeU = 1'b1; modeT = 4'($urandom);
                planHold(8'h1E, 1'b1, $urandom_range(0, 5), $urandom_range(0, 7));
                runPlan($sformatf("rnd%0d ulps", n), MAXL);
            end else begin
                modeL = 1'b0; modeU = 1'b0; modeT = 4'($urandom_range(1, 15));
                planHold(trigCmd(modeT), 1'b0, $urandom_range(0, 5), $urandom_range(0, 7));
                runPlan($sformatf("rnd%0d trig", n), MAXL);
            end
            idleGap($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
